// File: rtl/cla_pkg.sv
// Shared types and lookahead helpers for the pipelined carry-lookahead adder.
// PGW bounds the widest P/G vector the lookahead helper accepts.
package cla_pkg;

    localparam int PGW = 16;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic int nstg_of(input int width, input int group, input int gps);
        return width / (group * gps);
    endfunction

    function automatic bit cfg_ok(input int width, input int group, input int gps);
        return (group > 0) && (gps > 0) && (group <= PGW) && (gps <= PGW) &&
               ((width % (group * gps)) == 0);
    endfunction

    // Carry into position pos, written as the flat sum of products
    // G[j]&P[j+1..pos-1] plus cin&P[0..pos-1], so no ripple is implied.
    function automatic logic carry_at(input logic [PGW-1:0] p, input logic [PGW-1:0] g,
                                      input logic cin, input int pos);
        logic c;
        logic term;
        term = cin;
        for (int k = 0; k < PGW; k++) begin
            if (k < pos) term = term & p[k];
        end
        c = term;
        for (int j = 0; j < PGW; j++) begin
            if (j < pos) begin
                term = g[j];
                for (int k = 0; k < PGW; k++) begin
                    if ((k > j) && (k < pos)) term = term & p[k];
                end
                c = c | term;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Streaming operand/result bus of cla_pipe_adder; the sub signal exists only
// when CLA_PIPE_SUB_EN is defined.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_PIPE_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef CLA_PIPE_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
`ifdef CLA_PIPE_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_group.sv
// One combinational lookahead group: sum bits plus group propagate/generate
// for the second-level lookahead.
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output pg_t              pg
);
    logic [GROUP-1:0] pv;
    logic [GROUP-1:0] gv;
    logic [GROUP-1:0] c;

    assign pv = a ^ b;
    assign gv = a & b;

    for (genvar gi = 0; gi < GROUP; gi++) begin : g_carry
        assign c[gi] = carry_at(PGW'(pv), PGW'(gv), cin, gi);
    end

    assign s    = pv ^ c;
    assign pg.p = &pv;
    // Group generate is the carry out with a zero carry-in.
    assign pg.g = carry_at(PGW'(pv), PGW'(gv), 1'b0, GROUP);
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder with valid/ready flow control.
// Define CLA_PIPE_SUB_EN to add the sub port (a - b via inverted b and forced carry-in).
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4,
    parameter int GPS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    cla_pipe_adder_if.slave  bus
);
    localparam int SW   = GROUP * GPS;
    localparam int NSTG = nstg_of(WIDTH, GROUP, GPS);

    if (!cfg_ok(WIDTH, GROUP, GPS)) begin : g_cfg_err
        $error("cla_pipe_adder: WIDTH must be a multiple of GROUP*GPS, GROUP and GPS within PGW");
    end

    // Stage k register: remaining operand bits, sum bits formed so far, carry out of slice k.
    logic [NSTG-1:0]  v_reg;
    logic [WIDTH-1:0] a_reg [NSTG];
    logic [WIDTH-1:0] b_reg [NSTG];
    logic [WIDTH-1:0] s_reg [NSTG];
    logic             c_reg [NSTG];
    logic             ovf_reg;

    logic [NSTG-1:0]  v_next;
    logic [WIDTH-1:0] a_next [NSTG];
    logic [WIDTH-1:0] b_next [NSTG];
    logic [WIDTH-1:0] s_next [NSTG];
    logic             c_next [NSTG];
    logic             ovf_next;
    logic [NSTG-1:0]  rdy;

    // A stage can take new content when it is empty or its content leaves this cycle.
    always_comb begin
        logic r;
        r   = bus.out_ready;
        rdy = '0;
        for (int k = NSTG - 1; k >= 0; k--) begin
            r      = !v_reg[k] || r;
            rdy[k] = r;
        end
    end

    for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage
        logic             c_in;
        logic [WIDTH-1:0] s_prev;
        logic [WIDTH-1:0] s_loc;
        logic [SW-1:0]    s_slice;
        logic [GPS:0]     gc;
        pg_t  [GPS-1:0]   gpg;
        logic [GPS-1:0]   gp;
        logic [GPS-1:0]   gg;

        if (gi == 0) begin : g_head
            assign a_next[gi] = bus.a;
`ifdef CLA_PIPE_SUB_EN
            assign b_next[gi] = bus.b ^ {WIDTH{bus.sub}};
            assign c_in       = bus.cin | bus.sub;
`else
            assign b_next[gi] = bus.b;
            assign c_in       = bus.cin;
`endif
            assign s_prev     = '0;
            assign v_next[gi] = bus.in_valid;
        end else begin : g_body
            assign a_next[gi] = a_reg[gi-1];
            assign b_next[gi] = b_reg[gi-1];
            assign c_in       = c_reg[gi-1];
            assign s_prev     = s_reg[gi-1];
            assign v_next[gi] = v_reg[gi-1];
        end

        assign gc[0] = c_in;
        for (genvar gj = 0; gj < GPS; gj++) begin : g_grp
            cla_group #(
                .GROUP (GROUP)
            ) u_grp (
                .a   (a_next[gi][gi*SW + gj*GROUP +: GROUP]),
                .b   (b_next[gi][gi*SW + gj*GROUP +: GROUP]),
                .cin (gc[gj]),
                .s   (s_slice[gj*GROUP +: GROUP]),
                .pg  (gpg[gj])
            );
            assign gp[gj]    = gpg[gj].p;
            assign gg[gj]    = gpg[gj].g;
            assign gc[gj+1]  = carry_at(PGW'(gp), PGW'(gg), c_in, gj + 1);
        end

        always_comb begin
            s_loc = s_prev;
            s_loc[gi*SW +: SW] = s_slice;
        end

        assign s_next[gi] = s_loc;
        assign c_next[gi] = gc[GPS];

        if (gi == NSTG - 1) begin : g_tail
            // Carry into the MSB recovered from its sum bit: c = s ^ a ^ b.
            assign ovf_next = s_slice[SW-1] ^ a_next[gi][WIDTH-1] ^ b_next[gi][WIDTH-1] ^ gc[GPS];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_reg   <= '0;
            ovf_reg <= 1'b0;
            for (int k = 0; k < NSTG; k++) begin
                a_reg[k] <= '0;
                b_reg[k] <= '0;
                s_reg[k] <= '0;
                c_reg[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (rdy[k]) begin
                    v_reg[k] <= v_next[k];
                    if (v_next[k]) begin
                        a_reg[k] <= a_next[k];
                        b_reg[k] <= b_next[k];
                        s_reg[k] <= s_next[k];
                        c_reg[k] <= c_next[k];
                    end
                end
            end
            if (rdy[NSTG-1] && v_next[NSTG-1]) begin
                ovf_reg <= ovf_next;
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v_reg[NSTG-1];
    assign bus.sum       = s_reg[NSTG-1];
    assign bus.cout      = c_reg[NSTG-1];
    assign bus.ovf       = ovf_reg;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder (WIDTH=16, GROUP=4, GPS=1); result words are {cout, ovf, sum}.
// Operands are driven and outputs sampled on the falling clock edge.
module tb_cla_pipe_adder;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    cla_pipe_adder_if #(.WIDTH(16)) bus ();

    cla_pipe_adder #(
        .WIDTH (16),
        .GROUP (4),
        .GPS   (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] bp_a [8] = '{16'h0001, 16'h00FF, 16'h0F0F, 16'h1111,
                              16'h8000, 16'hFFFF, 16'h1234, 16'hABCD};
    logic [15:0] bp_b [8] = '{16'h0001, 16'h0001, 16'h00F1, 16'h2222,
                              16'h8000, 16'hFFFF, 16'h4321, 16'h1111};
    logic        bp_c [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [17:0] bp_e [8] = '{{2'b00, 16'h0002}, {2'b00, 16'h0100},
                              {2'b00, 16'h1000}, {2'b00, 16'h3334},
                              {2'b11, 16'h0000}, {2'b10, 16'hFFFF},
                              {2'b00, 16'h5555}, {2'b00, 16'hBCDF}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] result_word();
        return 32'({bus.cout, bus.ovf, bus.sum});
    endfunction

    task automatic present(input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
    endtask

    // One isolated transfer with out_ready high: result expected on the 4th falling edge.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [17:0] expv);
        int lat;
        present(a, b, cin);
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk(tag, result_word(), 32'(expv));
        @(negedge clk);
        chk({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int sent;
        int got;
        int cyc;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = 16'hAAAA;
        bus.b         = 16'h5555;
        bus.cin       = 1'b1;
        bus.out_ready = 1'b1;
`ifdef CLA_PIPE_SUB_EN
        bus.sub       = 1'b0;
`endif

        // Reset held for two edges with in_valid asserted.
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", result_word(), 32'd0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rst_quiet%0d", i), 32'(bus.out_valid), 32'd0);
        end

        run_op("add_1234_0fcd", 16'h1234, 16'h0FCD, 1'b1, {2'b00, 16'h2202});
        run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, {2'b10, 16'h0000});
        run_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, {2'b01, 16'h8000});
        run_op("add_aaaa_5555", 16'hAAAA, 16'h5555, 1'b1, {2'b10, 16'h0000});

        // Backpressure: fill with out_ready low, then drain while refilling.
        bus.out_ready = 1'b0;
        sent = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.in_ready && sent < 8) begin
                present(bp_a[sent], bp_b[sent], bp_c[sent]);
                sent++;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        chk("bp_accepts", 32'(sent), 32'd4);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_hold", result_word(), 32'(bp_e[0]));

        bus.out_ready = 1'b1;
        #1;
        chk("bp_ready_same_cycle", 32'(bus.in_ready), 32'd1);
        got = 0;
        cyc = 0;
        while (got < 8 && cyc < 40) begin
            if (bus.out_valid) begin
                chk($sformatf("bp_out%0d", got), result_word(), 32'(bp_e[got]));
                got++;
            end
            if (bus.in_ready && sent < 8) begin
                present(bp_a[sent], bp_b[sent], bp_c[sent]);
                sent++;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("bp_count", 32'(got), 32'd8);
        chk("bp_rate", 32'(cyc), 32'd8);
        chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

        // Reset with three operands in flight: nothing may come out.
        for (int i = 0; i < 3; i++) begin
            present(bp_a[i], bp_b[i], bp_c[i]);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("midrst_quiet%0d", i), 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        run_op("post_rst", 16'h00FF, 16'h0F01, 1'b0, {2'b00, 16'h1000});

`ifdef CLA_PIPE_SUB_EN
        bus.sub = 1'b1;
        run_op("sub_0005_0007", 16'h0005, 16'h0007, 1'b0, {2'b00, 16'hFFFE});
        run_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b0, {2'b11, 16'h7FFF});
        bus.sub = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
